// File: rtl/spi_master.sv
// SPI mode-0 master: one full-duplex byte per ss frame, sclk derived from a static divider.
// IDLE wait for byte | LEAD ss low, setup before first rise | SHIFT 8 sclk pulses | TRAIL hold ss after last fall | GAP ss high deselect
module spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       ss,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso
);
    typedef enum logic [2:0] {S_IDLE, S_LEAD, S_SHIFT, S_TRAIL, S_GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     r_state, w_state_nxt;
    logic [7:0] r_div, w_div_nxt;
    logic [2:0] r_bitn, w_bitn_nxt;
    logic       r_ph, w_ph_nxt;
    logic [7:0] r_tx_sh, w_tx_sh_nxt;
    logic [7:0] r_rx_sh, w_rx_sh_nxt;
    logic       r_ss, w_ss_nxt;
    logic       r_sclk, w_sclk_nxt;
    logic       r_mosi, w_mosi_nxt;
    logic [7:0] r_rx_data, w_rx_data_nxt;
    logic       r_rx_valid, w_rx_valid_nxt;
    logic       w_expire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_div      <= 8'd0;
            r_bitn     <= 3'd0;
            r_ph       <= 1'b0;
            r_tx_sh    <= 8'd0;
            r_rx_sh    <= 8'd0;
            r_ss       <= 1'b1;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_rx_data  <= 8'd0;
            r_rx_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_div      <= w_div_nxt;
            r_bitn     <= w_bitn_nxt;
            r_ph       <= w_ph_nxt;
            r_tx_sh    <= w_tx_sh_nxt;
            r_rx_sh    <= w_rx_sh_nxt;
            r_ss       <= w_ss_nxt;
            r_sclk     <= w_sclk_nxt;
            r_mosi     <= w_mosi_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_div_nxt      = r_div;
        w_bitn_nxt     = r_bitn;
        w_ph_nxt       = r_ph;
        w_tx_sh_nxt    = r_tx_sh;
        w_rx_sh_nxt    = r_rx_sh;
        w_ss_nxt       = r_ss;
        w_sclk_nxt     = r_sclk;
        w_mosi_nxt     = r_mosi;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;
        w_expire       = (r_div == DIV_LAST);

        // Every phase of every non-idle state is exactly CLK_DIV cycles long.
        if (r_state != S_IDLE) begin
            w_div_nxt = w_expire ? 8'd0 : r_div + 8'd1;
        end

        case (r_state)
            S_IDLE: begin
                w_div_nxt = 8'd0;
                if (tx_valid) begin
                    w_tx_sh_nxt = tx_data;
                    w_mosi_nxt  = tx_data[7];
                    w_ss_nxt    = 1'b0;
                    w_bitn_nxt  = 3'd0;
                    w_ph_nxt    = 1'b0;
                    w_state_nxt = S_LEAD;
                end
            end
            S_LEAD: begin
                if (w_expire) begin
                    w_sclk_nxt  = 1'b1;
                    w_rx_sh_nxt = {r_rx_sh[6:0], miso};
                    w_ph_nxt    = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_expire) begin
                    if (r_ph) begin
                        w_sclk_nxt = 1'b0;
                        if (r_bitn == 3'd7) begin
                            w_state_nxt = S_TRAIL;
                        end else begin
                            w_tx_sh_nxt = {r_tx_sh[6:0], 1'b0};
                            w_mosi_nxt  = r_tx_sh[6];
                            w_bitn_nxt  = r_bitn + 3'd1;
                            w_ph_nxt    = 1'b0;
                        end
                    end else begin
                        w_sclk_nxt  = 1'b1;
                        w_rx_sh_nxt = {r_rx_sh[6:0], miso};
                        w_ph_nxt    = 1'b1;
                    end
                end
            end
            S_TRAIL: begin
                if (w_expire) begin
                    w_ss_nxt       = 1'b1;
                    w_mosi_nxt     = 1'b0;
                    w_rx_data_nxt  = r_rx_sh;
                    w_rx_valid_nxt = 1'b1;
                    w_state_nxt    = S_GAP;
                end
            end
            S_GAP: begin
                if (w_expire) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign tx_ready = (r_state == S_IDLE);
    assign busy     = (r_state != S_IDLE);
    assign ss       = r_ss;
    assign sclk     = r_sclk;
    assign mosi     = r_mosi;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

endmodule
